// File: rtl/CPU_pkg.sv
// Shared CPU definitions: exception cause codes, fetch FSM states, fetch entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package CPU_pkg;

  // Exception cause codes carried with a fetch entry
  localparam logic [31:0] CAUSE_MISALIGNED_INST   = 32'd0;
  localparam logic [31:0] CAUSE_INST_ACCESS_FAULT = 32'd1;

  typedef enum logic [1:0] {
    FETCH,
    STALL,
    DISCARD,
    HALT
  } fetch_state_t;

  // One fetched instruction as presented to decode
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic        exc_pend;
    logic [31:0] exc_cause;
  } fetch_entry_t;

  // Exception entries always carry a zero instruction word
  function automatic fetch_entry_t exc_entry(input logic [31:0] pc, input logic [31:0] cause);
    fetch_entry_t e;
    e.pc        = pc;
    e.ir        = 32'd0;
    e.exc_pend  = 1'b1;
    e.exc_cause = cause;
    return e;
  endfunction

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry holding register for a fetch entry that arrived while the output was full.
// Latency: load visible the cycle after the load edge.
// Backpressure: none; the owner guarantees load only when empty or popped.
//
// Ports: clk/reset (async, active-low), load + load_entry write the entry,
// pop empties it, clear empties it with highest priority, vld/entry hold the contents.
module if_skid_buffer
  import CPU_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  fetch_entry_t load_entry,
  input  logic         pop,
  input  logic         clear,
  output logic         vld,
  output fetch_entry_t entry
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld   <= 1'b0;
      entry <= '0;
    end else if (clear) begin
      vld <= 1'b0;
    end else if (load) begin
      vld   <= 1'b1;
      entry <= load_entry;
    end else if (pop) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: single-outstanding imem requests, output register + one-entry skid to decode.
// Latency: ack in cycle N -> valid_out in N+1; 1 instr/cycle sustained with zero-wait memory.
// Backpressure: ready_in low parks one extra word in the skid entry and stops requesting (STALL).
//
// Ports:
//   clk, reset (async, active-low)
//   flush_in/flush_addr        downstream redirect, highest priority
//   valid_out/ready_in         handshake towards decode carrying PC_IF, IR_IF, exc_pend_IF, exc_cause_IF
//   jump_pred_IF/jump_addr_IF  decode's taken prediction for the presented instruction
//   imem_req/imem_addr         bus request, held until imem_ack
//   imem_ack/imem_rdata/imem_err  bus response
// Build option: define IMEM_ERR_EN to turn imem_err into access-fault entries; otherwise imem_err is ignored.
module if_stage
  import CPU_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_in,
  input  logic [31:0] flush_addr,
  output logic        valid_out,
  input  logic        ready_in,
  output logic [31:0] PC_IF,
  output logic [31:0] IR_IF,
  output logic        exc_pend_IF,
  output logic [31:0] exc_cause_IF,
  input  logic        jump_pred_IF,
  input  logic [31:0] jump_addr_IF,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err
);

  fetch_state_t state, state_n;
  logic [31:0]  pc_fetch, pc_n;
  logic         req_n;
  logic [31:0]  addr_n;

  logic         out_vld, out_vld_n;
  fetch_entry_t out_q, out_n;

  logic         skid_vld, skid_load, skid_pop, skid_clear;
  fetch_entry_t skid_q;

  logic         new_vld;
  fetch_entry_t new_entry;

  logic accept, free, ack_v, outstanding, misalign, bus_err;

`ifdef IMEM_ERR_EN
  assign bus_err = imem_err;
`else
  logic unused_imem_err;
  assign unused_imem_err = imem_err;
  assign bus_err         = 1'b0;
`endif

  assign accept      = out_vld & ready_in;
  assign free        = ~out_vld | accept;
  // An ack only counts against a request we actually issued (ignores stray acks after reset)
  assign ack_v       = imem_req & imem_ack;
  assign outstanding = imem_req & ~imem_ack;
  // A misaligned PC never reaches the bus, so imem_req is low while it waits here
  assign misalign    = (state == FETCH) && !imem_req && (pc_fetch[1:0] != 2'b00);

  if_skid_buffer u_skid (
    .clk        (clk),
    .reset      (reset),
    .load       (skid_load),
    .load_entry (new_entry),
    .pop        (skid_pop),
    .clear      (skid_clear),
    .vld        (skid_vld),
    .entry      (skid_q)
  );

  // Entry produced this cycle: a returned word, or a misaligned-PC exception
  always_comb begin
    new_vld   = 1'b0;
    new_entry = '0;
    if (state == FETCH && ack_v) begin
      new_vld = 1'b1;
      if (bus_err) begin
        new_entry = exc_entry(imem_addr, CAUSE_INST_ACCESS_FAULT);
      end else begin
        new_entry.pc = imem_addr;
        new_entry.ir = imem_rdata;
      end
    end else if (misalign) begin
      // Only raised once the output can take it; otherwise it waits in FETCH
      new_vld   = free;
      new_entry = exc_entry(pc_fetch, CAUSE_MISALIGNED_INST);
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc_fetch;
    out_vld_n  = out_vld;
    out_n      = out_q;
    skid_load  = 1'b0;
    skid_pop   = 1'b0;
    skid_clear = 1'b0;

    if (flush_in) begin
      out_vld_n  = 1'b0;
      skid_clear = 1'b1;
      pc_n       = flush_addr;
      state_n    = outstanding ? DISCARD : FETCH;
    end else if (accept && jump_pred_IF) begin
      // Skid and any word acked this cycle are sequential to a taken branch: drop them
      out_vld_n  = 1'b0;
      skid_clear = 1'b1;
      pc_n       = jump_addr_IF;
      state_n    = outstanding ? DISCARD : FETCH;
    end else begin
      if (free) begin
        if (skid_vld) begin
          out_vld_n = 1'b1;
          out_n     = skid_q;
          skid_pop  = 1'b1;
        end else if (new_vld) begin
          out_vld_n = 1'b1;
          out_n     = new_entry;
        end else begin
          out_vld_n = 1'b0;
        end
      end else if (new_vld) begin
        skid_load = 1'b1;
      end

      case (state)
        FETCH: begin
          if (ack_v) begin
            pc_n = pc_fetch + 32'd4;
            if (new_entry.exc_pend) state_n = HALT;
            else if (!free)         state_n = STALL;
          end else if (misalign && free) begin
            state_n = HALT;
          end
        end
        STALL:   if (accept) state_n = FETCH;
        DISCARD: if (ack_v)  state_n = FETCH;
        HALT:    ;
      endcase
    end

    // Bus outputs are registered; in DISCARD the old address is held until its ack
    case (state_n)
      DISCARD: begin
        req_n  = 1'b1;
        addr_n = imem_addr;
      end
      FETCH: begin
        req_n  = (pc_n[1:0] == 2'b00);
        addr_n = req_n ? pc_n : imem_addr;
      end
      default: begin
        req_n  = 1'b0;
        addr_n = imem_addr;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      pc_fetch  <= RESET_ADDR;
      imem_req  <= 1'b0;
      imem_addr <= 32'd0;
      out_vld   <= 1'b0;
      out_q     <= '0;
    end else begin
      state     <= state_n;
      pc_fetch  <= pc_n;
      imem_req  <= req_n;
      imem_addr <= addr_n;
      out_vld   <= out_vld_n;
      out_q     <= out_n;
    end
  end

  assign valid_out    = out_vld;
  assign PC_IF        = out_q.pc;
  assign IR_IF        = out_q.ir;
  assign exc_pend_IF  = out_q.exc_pend;
  assign exc_cause_IF = out_q.exc_cause;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] SIG = 32'hDEAD_0000;  // memory returns addr ^ SIG

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_in;
  logic [31:0] flush_addr;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] PC_IF, IR_IF, exc_cause_IF;
  logic        exc_pend_IF;
  logic        jump_pred_IF;
  logic [31:0] jump_addr_IF;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_err;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic        exc;
    logic [31:0] cause;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] req_q[$];
  int          checks = 0;
  int          errors = 0;
  int          waits  = 0;
  int          cnt;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = 32'd0;

  always #5 clk = ~clk;

  if_stage #(.RESET_ADDR(32'h0000_0100)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush_in     (flush_in),
    .flush_addr   (flush_addr),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .PC_IF        (PC_IF),
    .IR_IF        (IR_IF),
    .exc_pend_IF  (exc_pend_IF),
    .exc_cause_IF (exc_cause_IF),
    .jump_pred_IF (jump_pred_IF),
    .jump_addr_IF (jump_addr_IF),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .imem_err     (imem_err)
  );

  // Memory model: ack after 'waits' extra cycles
  always @(posedge clk or negedge reset) begin
    if (!reset)                    cnt <= 0;
    else if (imem_req && imem_ack) cnt <= 0;
    else if (imem_req)             cnt <= cnt + 1;
  end
  assign imem_ack   = imem_req && (cnt >= waits);
  assign imem_rdata = imem_addr ^ SIG;
  assign imem_err   = err_en && (imem_addr == err_addr);

  // Decode predicts the instruction at 0x200 taken to 0x400
  assign jump_pred_IF = valid_out && (PC_IF == 32'h0000_0200);
  assign jump_addr_IF = 32'h0000_0400;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  task automatic push_ent(input logic [31:0] pc, input logic [31:0] ir, input logic exc, input logic [31:0] cause);
    exp_t e;
    e.pc = pc; e.ir = ir; e.exc = exc; e.cause = cause;
    exp_q.push_back(e);
  endtask

  task automatic push_run(input logic [31:0] lo, input logic [31:0] hi);
    for (logic [31:0] a = lo; a <= hi; a += 32'd4) push_ent(a, a ^ SIG, 1'b0, 32'd0);
  endtask

  task automatic push_req(input logic [31:0] lo, input logic [31:0] hi);
    for (logic [31:0] a = lo; a <= hi; a += 32'd4) req_q.push_back(a);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input logic [31:0] pc, input int bound);
    bit found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk);
      if (valid_out && ready_in && PC_IF == pc) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_accept actual=timeout required=accept of pc %h", pc);
    end
  endtask

  // Output monitor: every accepted entry is checked against the scoreboard
  exp_t mon_e;
  always @(negedge clk) begin
    if (reset && valid_out && ready_in) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_entry actual pc=%h required=no entry", PC_IF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_pc", PC_IF, mon_e.pc);
        chk("out_ir", IR_IF, mon_e.ir);
        chk1("out_exc", exc_pend_IF, mon_e.exc);
        chk("out_cause", exc_cause_IF, mon_e.cause);
      end
    end
  end

  // Bus monitor: acked addresses in order, and requests held stable until ack
  logic        pend;
  logic [31:0] hold;
  always @(negedge clk) begin
    if (!reset) begin
      pend <= 1'b0;
    end else begin
      if (pend) begin
        chk1("req_held", imem_req, 1'b1);
        chk("addr_stable", imem_addr, hold);
      end
      if (imem_req && imem_ack) begin
        if (req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req actual addr=%h required=no request", imem_addr);
        end else begin
          chk("req_addr", imem_addr, req_q.pop_front());
        end
        pend <= 1'b0;
      end else if (imem_req) begin
        pend <= 1'b1;
        hold <= imem_addr;
      end else begin
        pend <= 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b0;
    flush_in   = 1'b0;
    flush_addr = 32'd0;
    ready_in   = 1'b1;

    // Whole-run expectations, in order
    push_req(32'h100, 32'h204);   // 0x204 is acked then dropped by the prediction
    push_req(32'h400, 32'h410);
    req_q.push_back(32'h300);     // completed in DISCARD, data dropped
    push_req(32'h80, 32'h90);
    req_q.push_back(32'h40);
    push_run(32'h100, 32'h200);
    push_run(32'h400, 32'h408);
    push_run(32'h80, 32'h88);
    push_ent(32'h82, 32'd0, 1'b1, 32'd0);
`ifdef IMEM_ERR_EN
    push_ent(32'h40, 32'd0, 1'b1, 32'd1);
`else
    push_ent(32'h40, 32'h40 ^ SIG, 1'b0, 32'd0);
    push_req(32'h44, 32'h48);
`endif
    push_ent(32'h42, 32'd0, 1'b1, 32'd0);

    // Reset state
    repeat (2) tick();
    chk1("rst_valid", valid_out, 1'b0);
    chk("rst_pc", PC_IF, 32'd0);
    chk("rst_ir", IR_IF, 32'd0);
    chk1("rst_exc", exc_pend_IF, 1'b0);
    chk("rst_cause", exc_cause_IF, 32'd0);
    chk1("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'd0);

    // Start-up streaming from RESET_ADDR
    reset = 1'b1;
    tick();
    chk1("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 32'h100);
    chk1("first_valid", valid_out, 1'b0);
    tick();
    chk("addr_c2", imem_addr, 32'h104);
    chk1("valid_c2", valid_out, 1'b1);
    chk("pc_c2", PC_IF, 32'h100);
    tick();
    chk("addr_c3", imem_addr, 32'h108);
    chk("pc_c3", PC_IF, 32'h104);

    // Decode stalls 3 cycles: 0x108 parks in skid, no requests
    ready_in = 1'b0;
    tick();
    chk1("stall_req_a", imem_req, 1'b0);
    tick();
    chk1("stall_req_b", imem_req, 1'b0);
    chk1("stall_valid", valid_out, 1'b1);
    chk("stall_pc", PC_IF, 32'h104);
    tick();
    ready_in = 1'b1;

    // Prediction at 0x200 -> 0x400, then park in STALL before redirecting
    wait_accept(32'h200, 200);
    wait_accept(32'h408, 50);
    tick();
    ready_in = 1'b0;
    repeat (10) tick();

    // Flush to 0x300 with slow memory, then flush to 0x80 while 0x300 is pending
    flush_in   = 1'b1;
    flush_addr = 32'h300;
    waits      = 2;
    tick();
    flush_addr = 32'h80;
    tick();
    flush_in = 1'b0;
    ready_in = 1'b1;
    chk1("discard_req", imem_req, 1'b1);
    chk("discard_addr_a", imem_addr, 32'h300);
    tick();
    chk("discard_addr_b", imem_addr, 32'h300);
    tick();
    chk1("refetch_req", imem_req, 1'b1);
    chk("refetch_addr", imem_addr, 32'h80);

    // Misaligned flush target: exception entry, then HALT
    wait_accept(32'h88, 60);
    tick();
    ready_in = 1'b0;
    repeat (10) tick();
    flush_in   = 1'b1;
    flush_addr = 32'h82;
    waits      = 0;
    tick();
    flush_in = 1'b0;
    ready_in = 1'b1;
    repeat (6) tick();
    chk1("halt_req", imem_req, 1'b0);
    chk1("halt_valid", valid_out, 1'b0);

    // Bus error at 0x40
    err_en     = 1'b1;
    err_addr   = 32'h40;
    flush_in   = 1'b1;
    flush_addr = 32'h40;
    tick();
    flush_in = 1'b0;
    wait_accept(32'h40, 20);
    tick();
    ready_in = 1'b0;
    err_en   = 1'b0;
    repeat (10) tick();
    flush_in   = 1'b1;
    flush_addr = 32'h42;
    tick();
    flush_in = 1'b0;
    ready_in = 1'b1;
    repeat (8) tick();

    chk("entries_left", 32'(exp_q.size()), 32'd0);
    chk("reqs_left", 32'(req_q.size()), 32'd0);
    chk1("final_halt_req", imem_req, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
